// File: rtl/moon_path_ctrl.sv
// moon_path_ctrl
//   Steps the moon centre along a rise / cross / set / hidden night-sky path,
//   advancing once per video frame. The frame tick is taken from the vertical
//   counter on line V_TICK_LINE, which lies in vertical blanking, so the
//   coordinates never change while a frame is being drawn.
//
// Ports
//   clk         pixel clock
//   rst         asynchronous, active-high reset
//   vcount      raster line counter (signed 11 bit)
//   enable      1 = advance the path on frame ticks, 0 = freeze
//   moonX       moon centre x (signed 12 bit, registered)
//   moonY       moon centre y (signed 12 bit, registered)
//   night       1 while the moon is in RISE, CROSS or SET
//   cycle_done  one-clk pulse when the HIDDEN phase completes
//
// Optional feature
//   MOON_PATH_FRAME_DIV_EN: when defined, only every FRAME_DIV-th enabled
//   frame tick advances the path (the path runs FRAME_DIV times slower).
module moon_path_ctrl #(
  parameter int X_START     = -40,
  parameter int Y_HORIZON   = 480,
  parameter int Y_TOP       = 60,
  parameter int Y_HIDDEN    = 600,
  parameter int X_STEP      = 1,
  parameter int Y_STEP      = 2,
  parameter int X_SET_BEGIN = 470,
  parameter int HIDE_FRAMES = 60,
  parameter int V_TICK_LINE = 481
`ifdef MOON_PATH_FRAME_DIV_EN
  ,
  parameter int FRAME_DIV   = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] vcount,
  input  logic               enable,
  output logic signed [11:0] moonX,
  output logic signed [11:0] moonY,
  output logic               night,
  output logic               cycle_done
);

  // All path arithmetic is done at 13 bits so sums near the 12-bit
  // extremes cannot wrap before being compared.
  localparam logic signed [12:0] X_START_W   = 13'(X_START);
  localparam logic signed [12:0] Y_HORIZON_W = 13'(Y_HORIZON);
  localparam logic signed [12:0] Y_TOP_W     = 13'(Y_TOP);
  localparam logic signed [12:0] Y_HIDDEN_W  = 13'(Y_HIDDEN);
  localparam logic signed [12:0] X_STEP_W    = 13'(X_STEP);
  localparam logic signed [12:0] Y_STEP_W    = 13'(Y_STEP);
  localparam logic signed [12:0] X_SET_W     = 13'(X_SET_BEGIN);
  localparam logic signed [10:0] V_TICK      = 11'(V_TICK_LINE);

  localparam int HIDE_W = (HIDE_FRAMES > 1) ? $clog2(HIDE_FRAMES) : 1;
  localparam logic [HIDE_W-1:0] HIDE_LAST = HIDE_W'(HIDE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RISE   = 3'd1,
    CROSS  = 3'd2,
    SET    = 3'd3,
    HIDDEN = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;
  logic signed [10:0]  vcount_d;
  logic [HIDE_W-1:0]   hide_cnt;
  logic [HIDE_W-1:0]   hide_next;
  logic signed [11:0]  x_next;
  logic signed [11:0]  y_next;
  logic                night_next;
  logic                done_next;
  logic                tick;
  logic                step;

  logic signed [12:0]  x_ext;
  logic signed [12:0]  y_ext;
  logic signed [12:0]  x_inc;
  logic signed [12:0]  y_dec;
  logic signed [12:0]  y_inc;

  // Rising edge of "vcount is on the tick line": a counter that stalls on
  // the line yields a single tick only.
  assign tick = (vcount == V_TICK) && (vcount_d != V_TICK);

`ifdef MOON_PATH_FRAME_DIV_EN
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Counts only enabled raw ticks, so the divider freezes with the path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick && enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : DIV_W'(div_cnt + 1'b1);
    end
  end

  assign step = tick && enable && (div_cnt == DIV_LAST);
`else
  assign step = tick && enable;
`endif

  assign x_ext = {moonX[11], moonX};
  assign y_ext = {moonY[11], moonY};
  assign x_inc = x_ext + X_STEP_W;
  assign y_dec = y_ext - Y_STEP_W;
  assign y_inc = y_ext + Y_STEP_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      moonX      <= X_START_W[11:0];
      moonY      <= Y_HIDDEN_W[11:0];
      night      <= 1'b0;
      cycle_done <= 1'b0;
      hide_cnt   <= '0;
      vcount_d   <= '0;
    end else begin
      state      <= state_next;
      moonX      <= x_next;
      moonY      <= y_next;
      night      <= night_next;
      cycle_done <= done_next;
      hide_cnt   <= hide_next;
      vcount_d   <= vcount;
    end
  end

  always_comb begin
    state_next = state;
    x_next     = moonX;
    y_next     = moonY;
    hide_next  = hide_cnt;
    done_next  = 1'b0;

    if (step) begin
      unique case (state)
        IDLE: begin
          x_next     = X_START_W[11:0];
          y_next     = Y_HORIZON_W[11:0];
          state_next = RISE;
        end
        RISE: begin
          x_next = x_inc[11:0];
          // Clamp exactly onto the cruising height instead of overshooting.
          if (y_dec <= Y_TOP_W) begin
            y_next     = Y_TOP_W[11:0];
            state_next = CROSS;
          end else begin
            y_next = y_dec[11:0];
          end
        end
        CROSS: begin
          x_next = x_inc[11:0];
          if (x_inc >= X_SET_W) begin
            state_next = SET;
          end
        end
        SET: begin
          x_next = x_inc[11:0];
          // Reaching the horizon parks the moon below the screen.
          if (y_inc >= Y_HORIZON_W) begin
            y_next     = Y_HIDDEN_W[11:0];
            hide_next  = '0;
            state_next = HIDDEN;
          end else begin
            y_next = y_inc[11:0];
          end
        end
        HIDDEN: begin
          if (hide_cnt == HIDE_LAST) begin
            x_next     = X_START_W[11:0];
            y_next     = Y_HORIZON_W[11:0];
            hide_next  = '0;
            done_next  = 1'b1;
            state_next = RISE;
          end else begin
            hide_next = HIDE_W'(hide_cnt + 1'b1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    night_next = (state_next == RISE) || (state_next == CROSS) ||
                 (state_next == SET);
  end

endmodule

// File: tb/tb_moon_path_ctrl.sv
// tb_moon_path_ctrl
//   Scoreboard bench for moon_path_ctrl at default parameters. Each driven
//   frame pushes the expected outputs, computed from a closed-form description
//   of the path (position as a function of effective tick count), and the
//   entry is popped and compared one clock after the tick edge.
module tb_moon_path_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [10:0] vcount;
  logic               enable;
  logic signed [11:0] moonX;
  logic signed [11:0] moonY;
  logic               night;
  logic               cycle_done;

  always #5 clk = ~clk;

  moon_path_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vcount     (vcount),
    .enable     (enable),
    .moonX      (moonX),
    .moonY      (moonY),
    .night      (night),
    .cycle_done (cycle_done)
  );

  typedef struct {
    int x;
    int y;
    int nt;
    int cd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n        = 0;   // effective ticks since reset

  // Path as a function of tick count k. p = steps since (-40,480):
  // rise p=0..210, cross to p=510, set to p=720, hidden until p=779.
  function automatic exp_t model(input int k);
    exp_t e;
    int   p;
    if (k == 0) begin
      e.x = -40; e.y = 600; e.nt = 0; e.cd = 0;
      return e;
    end
    p    = (k - 1) % 780;
    e.x  = (p <= 720) ? (-40 + p) : 680;
    if (p <= 210)      e.y = 480 - 2 * p;
    else if (p <= 510) e.y = 60;
    else if (p <= 719) e.y = 60 + 2 * (p - 510);
    else               e.y = 600;
    e.nt = (p < 720) ? 1 : 0;
    e.cd = (p == 0 && k > 1) ? 1 : 0;
    return e;
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, n);
  endtask

  task automatic push_exp(input bit advanced);
    exp_t e;
    e = model(n);
    if (!advanced) e.cd = 0;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check_val("moonX", moonX, e.x);
      check_val("moonY", moonY, e.y);
      check_val("night", night, e.nt);
      check_val("cycle_done", cycle_done, e.cd);
    end
  endtask

  // Entered and left at #1 after a posedge. One tick-line clock, one
  // ordinary-line clock per frame.
  task automatic frame(input bit en);
    bit cd_exp;
    vcount = 11'sd481;
    enable = en;
    if (en) n++;
    push_exp(en);
    cd_exp = sb[sb.size()-1].cd[0];
    @(posedge clk); #1;
    $display("tick %0d en=%0d x=%0d y=%0d night=%0d done=%0d",
             n, en, moonX, moonY, night, cycle_done);
    pop_compare();
    vcount = 11'sd0;
    @(posedge clk); #1;
    if (cd_exp) check_val("cycle_done_one_clk", cycle_done, 0);
  endtask

  task automatic run_to(input int target);
    while (n < target) frame(1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    vcount = 11'sd0;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_x", moonX, -40);
    check_val("rst_y", moonY, 600);
    check_val("rst_night", night, 0);
    check_val("rst_done", cycle_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_y", moonY, 600);

    frame(1'b1);
    check_val("first_tick_y", moonY, 480);
    check_val("first_tick_night", night, 1);

    run_to(211);
    check_val("rise_end_x", moonX, 170);
    check_val("rise_end_y", moonY, 60);
    frame(1'b1);
    check_val("cross_x", moonX, 171);
    check_val("cross_y", moonY, 60);

    // Freeze mid-cross.
    run_to(341);
    check_val("pre_freeze_x", moonX, 300);
    repeat (20) frame(1'b0);
    check_val("freeze_x", moonX, 300);
    check_val("freeze_y", moonY, 60);
    frame(1'b1);
    check_val("unfreeze_x", moonX, 301);

    run_to(721);
    check_val("set_end_x", moonX, 680);
    check_val("set_end_y", moonY, 600);
    check_val("set_end_night", night, 0);
    run_to(781);
    check_val("restart_x", moonX, -40);
    check_val("restart_y", moonY, 480);

    // Stalled vcount on the tick line: exactly two ticks.
    vcount = 11'sd481;
    enable = 1'b1;
    n++;
    push_exp(1'b0);
    repeat (100) @(posedge clk);
    #1;
    $display("stall hold x=%0d y=%0d", moonX, moonY);
    pop_compare();
    vcount = 11'sd482;
    @(posedge clk); #1;
    vcount = 11'sd481;
    n++;
    push_exp(1'b0);
    @(posedge clk); #1;
    $display("stall retick x=%0d y=%0d", moonX, moonY);
    pop_compare();
    vcount = 11'sd0;
    @(posedge clk); #1;
    check_val("stall_x", moonX, -38);

    // Asynchronous reset in SET takes effect before the next edge.
    run_to(1380);
    check_val("in_set_night", night, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_x", moonX, -40);
    check_val("async_rst_y", moonY, 600);
    check_val("async_rst_night", night, 0);
    check_val("async_rst_done", cycle_done, 0);
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) frame(1'b1);
    check_val("post_rst_x", moonX, -38);
    check_val("post_rst_y", moonY, 476);
    check_val("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moon_path_ctrl.md
Name: moon_path_ctrl

Overview:
- Sequential producer of the moon centre coordinates (moonX, moonY) consumed by the moon pixel-test renderer.
- Watches the VGA vertical counter, detects one frame tick per frame, and steps the moon along a rise / cross / set / hidden night-sky path.
- Outputs change only at the frame tick, which falls in vertical blanking, so the moon never tears mid-frame.
- Also exports a night flag and an end-of-cycle pulse for sky and colour logic.

Parameters:
- X_START, -40: moonX at start of each cycle (signed 12-bit, off-screen left).
- Y_HORIZON, 480: moonY at rise start.
- Y_TOP, 60: cruising moonY.
- Y_HIDDEN, 600: moonY while hidden or idle (below the screen).
- X_STEP, 1: moonX increment per tick in RISE, CROSS and SET.
- Y_STEP, 2: moonY change per tick in RISE and SET.
- X_SET_BEGIN, 470: moonX at which CROSS ends.
- HIDE_FRAMES, 60: ticks spent in HIDDEN (at least 1).
- V_TICK_LINE, 481: vcount value that generates the frame tick.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- vcount  in  11 signed  raster line counter
- enable  in  1  advance the path when 1; freeze when 0
- moonX  out  12 signed  moon centre x, registered
- moonY  out  12 signed  moon centre y, registered
- night  out  1  1 while state is RISE, CROSS or SET
- cycle_done  out  1  one-clk pulse when HIDDEN completes

Behaviour:
- **Frame tick.**
  - vcount_d is vcount registered; it resets to 0.
  - tick = (vcount == V_TICK_LINE) && (vcount_d != V_TICK_LINE), so there is exactly one tick per frame.
  - A vcount that stalls on V_TICK_LINE produces no further ticks.
- **Reset** (asynchronous, dominant over everything):
  - state = IDLE, moonX = X_START, moonY = Y_HIDDEN.
  - night = 0, cycle_done = 0, hide_cnt = 0, vcount_d = 0.
  - Reset mid-cycle abandons the path immediately.
- **Timing and freeze.**
  - All updates happen on the clk edge where tick = 1. Outputs are valid from the next cycle (latency 1 clk).
  - Ticks with enable = 0 are ignored in every state: position and hide_cnt are frozen.
- **IDLE.** On tick with enable: moonY <= Y_HORIZON, moonX <= X_START, go to RISE.
- **RISE.** On tick with enable:
  - moonX += X_STEP.
  - If moonY - Y_STEP <= Y_TOP: moonY <= Y_TOP and go to CROSS.
  - Otherwise moonY -= Y_STEP.
- **CROSS.** On tick with enable:
  - moonX += X_STEP; moonY holds.
  - If moonX + X_STEP >= X_SET_BEGIN, go to SET.
- **SET.** On tick with enable:
  - moonX += X_STEP.
  - If moonY + Y_STEP >= Y_HORIZON: moonY <= Y_HIDDEN, hide_cnt <= 0, go to HIDDEN.
  - Otherwise moonY += Y_STEP.
- **HIDDEN.** On tick with enable:
  - If hide_cnt == HIDE_FRAMES-1: moonX <= X_START, moonY <= Y_HORIZON, cycle_done = 1 for one clk, go to RISE.
  - Otherwise hide_cnt += 1.
- **night** is registered: 1 exactly when state is RISE, CROSS or SET.
- **Arithmetic.**
  - Compares and sums are computed sign-extended to 13 bits, so there is no overflow at coordinate extremes.
  - Clamps to Y_TOP and Y_HIDDEN are exact.
- **Cycle length at default parameters:**
  - RISE: 210 ticks, ends at (170, 60).
  - CROSS: 300 ticks, ends at X = 470.
  - SET: 210 ticks, ends at X = 680, Y = 600.
  - HIDDEN: 60 ticks.
  - Total: 780 ticks per cycle.

Optional Feature:
- Macro MOON_PATH_FRAME_DIV_EN.
- When defined:
  - Adds parameter FRAME_DIV (default 4) and an internal divider counter, which resets to 0.
  - An effective tick occurs on every FRAME_DIV-th raw tick that arrives with enable = 1, so the whole path runs FRAME_DIV times slower.
  - The divider is frozen while enable = 0.
- When undefined: every raw tick is effective and there is no divider logic.

Test Plan:
- Reset, hold rst 5 clks, then drive frames with enable = 1 -> before the first tick: moonX = -40, moonY = 600, night = 0, cycle_done = 0. After tick 1: moonY = 480, night = 1.
- 211 ticks after reset with enable = 1 -> moonX = 170, moonY = 60, state CROSS. One more tick -> (171, 60).
- 721 ticks -> moonX = 680, moonY = 600, night = 0. 60 further ticks -> cycle_done high for exactly one clk, then moonX = -40, moonY = 480.
- Drop enable for 20 frames mid-CROSS at X = 300 -> moonX stays 300 and moonY stays 60. Re-enable, next tick -> moonX = 301.
- Hold vcount at 481 for 100 clks, then 482, then 481 again -> exactly two ticks counted.
- Assert rst during SET -> outputs return to (-40, 600), night = 0 within the same cycle. With MOON_PATH_FRAME_DIV_EN and FRAME_DIV = 4, the first RISE step occurs after 8 raw ticks.
